// File: rtl/fp_align.sv
// Operand alignment front end of the binary32 adder: unpack, order by
// magnitude and iteratively right-shift the smaller mantissa with G/R/S.
module fp_align #(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_mantL,
    output logic [23:0] out_mantS,
    output logic [7:0]  out_exponent,
    output logic        out_signL,
    output logic        out_signS,
    output logic        out_guard,
    output logic        out_round,
    output logic        out_sticky,
    output logic        out_swapped,
    output logic        out_special
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [5:0] STEP = SHIFT_STEP[5:0];

    state_t      state;
    state_t      stateNext;

    logic [25:0] shReg;
    logic        stickyQ;
    logic [4:0]  remaining;

    logic [7:0]  expA;
    logic [7:0]  expB;
    logic [7:0]  effExpA;
    logic [7:0]  effExpB;
    logic [23:0] mantA;
    logic [23:0] mantB;
    logic        bLarger;
    logic        special;

    logic [7:0]  expL;
    logic [7:0]  expS;
    logic [23:0] mantL;
    logic [23:0] mantS;
    logic        signL;
    logic        signS;
    logic [7:0]  diff;
    logic [4:0]  remInit;

    logic [5:0]  stepN;
    logic [25:0] shifted;
    logic [25:0] lostMask;
    logic        lost;

    // Unpack: a zero exponent field means no hidden bit and exponent 1
    always_comb begin
        expA    = opA[30:23];
        expB    = opB[30:23];
        effExpA = (expA == 8'd0) ? 8'd1 : expA;
        effExpB = (expB == 8'd0) ? 8'd1 : expB;
        mantA   = {expA != 8'd0, opA[22:0]};
        mantB   = {expB != 8'd0, opB[22:0]};
        special = (expA == 8'hFF) || (expB == 8'hFF);
    end

    // Full ties resolve to A as the larger operand
    always_comb begin
        bLarger = {effExpB, opB[22:0]} > {effExpA, opA[22:0]};
        if (bLarger) begin
            expL  = effExpB;
            expS  = effExpA;
            mantL = mantB;
            mantS = mantA;
            signL = opB[31];
            signS = opA[31];
        end else begin
            expL  = effExpA;
            expS  = effExpB;
            mantL = mantA;
            mantS = mantB;
            signL = opA[31];
            signS = opB[31];
        end
        diff = expL - expS;
        if (special) begin
            remInit = 5'd0;
        end else if (diff > 8'd26) begin
            remInit = 5'd26;
        end else begin
            remInit = diff[4:0];
        end
    end

    always_comb begin
        if ({1'b0, remaining} < STEP) begin
            stepN = {1'b0, remaining};
        end else begin
            stepN = STEP;
        end
        shifted  = shReg >> stepN;
        lostMask = ~(26'h3FF_FFFF << stepN);
        lost     = |(shReg & lostMask);
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    stateNext = SHIFT;
                end
            end
            SHIFT: begin
                if (remaining == 5'd0) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shReg        <= '0;
            stickyQ      <= 1'b0;
            remaining    <= '0;
            out_mantL    <= '0;
            out_exponent <= '0;
            out_signL    <= 1'b0;
            out_signS    <= 1'b0;
            out_swapped  <= 1'b0;
            out_special  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        shReg        <= {mantS, 2'b00};
                        stickyQ      <= 1'b0;
                        remaining    <= remInit;
                        out_mantL    <= mantL;
                        out_exponent <= special ? 8'hFF : expL;
                        out_signL    <= signL;
                        out_signS    <= signS;
                        out_swapped  <= bLarger;
                        out_special  <= special;
                    end
                end
                SHIFT: begin
                    if (remaining != 5'd0) begin
                        shReg     <= shifted;
                        stickyQ   <= stickyQ | lost;
                        remaining <= remaining - stepN[4:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign out_mantS  = shReg[25:2];
    assign out_guard  = shReg[1];
    assign out_round  = shReg[0];
    assign out_sticky = stickyQ;

endmodule

// File: tb/tb_fp_align.sv
// Directed bench for fp_align: hand-computed alignment vectors,
// latency, backpressure and mid-operation reset.
module tb_fp_align;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_mantL;
    logic [23:0] out_mantS;
    logic [7:0]  out_exponent;
    logic        out_signL;
    logic        out_signS;
    logic        out_guard;
    logic        out_round;
    logic        out_sticky;
    logic        out_swapped;
    logic        out_special;

    int nCmp;
    int nBad;

    fp_align #(.SHIFT_STEP(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .opA(opA),
        .opB(opB),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mantL(out_mantL),
        .out_mantS(out_mantS),
        .out_exponent(out_exponent),
        .out_signL(out_signL),
        .out_signS(out_signS),
        .out_guard(out_guard),
        .out_round(out_round),
        .out_sticky(out_sticky),
        .out_swapped(out_swapped),
        .out_special(out_special)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operand pair; lat = edges after capture until out_valid
    task automatic runOp(input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        @(negedge clk);
        opA = a;
        opB = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        nCmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL reset_hs got rdy=%b vld=%b want 1/0",
                     in_ready, out_valid);
            nBad++;
        end
        nCmp++;
        if ({out_mantL, out_mantS, out_exponent, out_guard, out_round,
             out_sticky, out_swapped, out_special, out_signL,
             out_signS} !== '0) begin
            $display("FAIL reset_outs got L=%h S=%h e=%h want 0",
                     out_mantL, out_mantS, out_exponent);
            nBad++;
        end
    endtask

    task automatic test_basic();
        int lat;
        runOp(32'h3F80_0000, 32'h3F00_0000, lat);
        nCmp++;
        if (lat !== 2) begin
            $display("FAIL basic_lat got %0d want 2", lat);
            nBad++;
        end
        nCmp++;
        if (out_mantL !== 24'h80_0000 || out_mantS !== 24'h40_0000 ||
            out_exponent !== 8'h7F) begin
            $display("FAIL basic_val got L=%h S=%h e=%h want 800000/400000/7f",
                     out_mantL, out_mantS, out_exponent);
            nBad++;
        end
        nCmp++;
        if ({out_guard, out_round, out_sticky, out_swapped,
             out_special} !== 5'b0) begin
            $display("FAIL basic_bits got %b want 00000",
                     {out_guard, out_round, out_sticky, out_swapped,
                      out_special});
            nBad++;
        end
        release_out();
    endtask

    task automatic test_swap();
        int lat;
        runOp(32'h3F80_0000, 32'h3F80_0001, lat);
        nCmp++;
        if (lat !== 1) begin
            $display("FAIL swap_lat got %0d want 1", lat);
            nBad++;
        end
        nCmp++;
        if (out_swapped !== 1'b1 || out_mantL !== 24'h80_0001 ||
            out_mantS !== 24'h80_0000 || out_exponent !== 8'h7F) begin
            $display("FAIL swap_val got sw=%b L=%h S=%h e=%h want 1/800001/800000/7f",
                     out_swapped, out_mantL, out_mantS, out_exponent);
            nBad++;
        end
        release_out();
    endtask

    task automatic test_sign();
        int lat;
        runOp(32'h3F80_0000, 32'hC000_0000, lat);
        nCmp++;
        if (out_signL !== 1'b1 || out_signS !== 1'b0 ||
            out_swapped !== 1'b1 || out_exponent !== 8'h80 ||
            out_mantS !== 24'h40_0000) begin
            $display("FAIL sign_val got sL=%b sS=%b sw=%b e=%h S=%h want 1/0/1/80/400000",
                     out_signL, out_signS, out_swapped, out_exponent,
                     out_mantS);
            nBad++;
        end
        release_out();
    endtask

    task automatic test_grs();
        int lat;
        runOp(32'h4000_0000, 32'h3F7F_FFFF, lat);
        nCmp++;
        if (lat !== 2 || out_mantS !== 24'h3F_FFFF || out_guard !== 1'b1 ||
            out_round !== 1'b1 || out_sticky !== 1'b0) begin
            $display("FAIL grs_d2 got lat=%0d S=%h grs=%b%b%b want 2/3fffff/110",
                     lat, out_mantS, out_guard, out_round, out_sticky);
            nBad++;
        end
        release_out();
        runOp(32'h4200_0000, 32'h3F80_001F, lat);
        nCmp++;
        if (lat !== 3 || out_mantS !== 24'h04_0000 || out_guard !== 1'b1 ||
            out_round !== 1'b1 || out_sticky !== 1'b1 ||
            out_exponent !== 8'h84) begin
            $display("FAIL grs_d5 got lat=%0d S=%h grs=%b%b%b e=%h want 3/040000/111/84",
                     lat, out_mantS, out_guard, out_round, out_sticky,
                     out_exponent);
            nBad++;
        end
        release_out();
    endtask

    task automatic test_long_shift();
        int lat;
        runOp(32'h4B80_0000, 32'h3F80_0001, lat);
        nCmp++;
        if (lat !== 7) begin
            $display("FAIL d24_lat got %0d want 7", lat);
            nBad++;
        end
        nCmp++;
        if (out_mantS !== 24'h0 || out_guard !== 1'b1 || out_round !== 1'b0 ||
            out_sticky !== 1'b1 || out_exponent !== 8'h97) begin
            $display("FAIL d24_val got S=%h grs=%b%b%b e=%h want 0/101/97",
                     out_mantS, out_guard, out_round, out_sticky, out_exponent);
            nBad++;
        end
        release_out();
        runOp(32'h7F00_0000, 32'h3F80_0000, lat);
        nCmp++;
        if (lat !== 8) begin
            $display("FAIL clamp_lat got %0d want 8", lat);
            nBad++;
        end
        nCmp++;
        if (out_mantS !== 24'h0 || out_guard !== 1'b0 || out_round !== 1'b0 ||
            out_sticky !== 1'b1 || out_exponent !== 8'hFE) begin
            $display("FAIL clamp_val got S=%h grs=%b%b%b e=%h want 0/001/fe",
                     out_mantS, out_guard, out_round, out_sticky, out_exponent);
            nBad++;
        end
        release_out();
    endtask

    task automatic test_special();
        int lat;
        runOp(32'h7F80_0000, 32'h3F80_0000, lat);
        nCmp++;
        if (lat !== 1 || out_special !== 1'b1 || out_exponent !== 8'hFF ||
            out_mantS !== 24'h80_0000 || out_mantL !== 24'h80_0000) begin
            $display("FAIL special got lat=%0d sp=%b e=%h L=%h S=%h want 1/1/ff/800000/800000",
                     lat, out_special, out_exponent, out_mantL, out_mantS);
            nBad++;
        end
        release_out();
    endtask

    task automatic test_zero();
        int lat;
        runOp(32'h0000_0000, 32'h0000_0001, lat);
        nCmp++;
        if (lat !== 1 || out_swapped !== 1'b1 || out_mantL !== 24'h00_0001 ||
            out_mantS !== 24'h0 || out_exponent !== 8'h01 ||
            out_special !== 1'b0) begin
            $display("FAIL zero got lat=%0d sw=%b L=%h S=%h e=%h want 1/1/000001/0/01",
                     lat, out_swapped, out_mantL, out_mantS, out_exponent);
            nBad++;
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [23:0] sL;
        logic [23:0] sS;
        logic [7:0]  sE;
        runOp(32'h3F80_0000, 32'h3F00_0000, lat);
        sL = 24'h80_0000;
        sS = 24'h40_0000;
        sE = 8'h7F;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            nCmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_mantL !== sL || out_mantS !== sS ||
                out_exponent !== sE) begin
                $display("FAIL bp_hold%0d got v=%b r=%b L=%h S=%h e=%h want 1/0/%h/%h/%h",
                         i, out_valid, in_ready, out_mantL, out_mantS,
                         out_exponent, sL, sS, sE);
                nBad++;
            end
        end
        release_out();
        nCmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            out_mantS !== sS || out_mantL !== sL) begin
            $display("FAIL bp_release got r=%b v=%b L=%h S=%h want 1/0/%h/%h",
                     in_ready, out_valid, out_mantL, out_mantS, sL, sS);
            nBad++;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        opA = 32'h4B80_0000;
        opB = 32'h3F80_0001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        nCmp++;
        if (in_ready !== 1'b0) begin
            $display("FAIL mid_busy got r=%b want 0", in_ready);
            nBad++;
        end
        rst_n = 1'b0;
        #1;
        nCmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            {out_mantL, out_mantS, out_exponent, out_guard, out_round,
             out_sticky, out_swapped, out_special, out_signL,
             out_signS} !== '0) begin
            $display("FAIL mid_reset got r=%b v=%b L=%h S=%h e=%h want 1/0/0/0/0",
                     in_ready, out_valid, out_mantL, out_mantS, out_exponent);
            nBad++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            nCmp++;
            if (out_valid !== 1'b0) begin
                $display("FAIL mid_noout%0d got v=%b want 0", i, out_valid);
                nBad++;
            end
        end
    endtask

    initial begin
        nCmp = 0;
        nBad = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        opA = '0;
        opB = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
        test_swap();
        test_sign();
        test_grs();
        test_long_shift();
        test_special();
        test_zero();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
